axi_slice_param: RTL and testbench

- Parametrised AXI4 register/buffer slice. Sits between an `AXI_BUS.Master` and an `AXI_BUS.Slave` port, for example between the core/debug masters and the crossbar, or between the crossbar and a peripheral.
- Each of the five channels (AW, AR, W, R, B) gets an independently sized FIFO; depth 0 means combinational pass-through.
- Breaks timing paths and absorbs back-pressure bursts. Carries the full `AXI_BUS` signal set, including region/qos/user.

---
 rtl/axi_slice_pkg.sv | 37 +++
 rtl/axi_slice_fifo.sv | 69 ++++++
 rtl/axi_slice_param.sv | 111 +++++++++++
 tb/tb_axi_slice_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
// Shared widths and constants for the parametrised AXI slice.
// Payload widths are derived from the AXI bus widths so every channel packs into one vector.
package axi_slice_pkg;

  localparam int unsigned LEVEL_W = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] AXI_RESP_OKAY = RESP_OKAY;

  // prot(3) + region(4) + len(8) + size(3) + burst(2) + lock(1) + cache(4) + qos(4)
  localparam int unsigned AX_FIXED_W = 29;

  function automatic int unsigned ax_payload_w(int unsigned addr_w, int unsigned id_w,
                                               int unsigned user_w);
    return addr_w + AX_FIXED_W + id_w + user_w;
  endfunction

  function automatic int unsigned w_payload_w(int unsigned data_w, int unsigned user_w);
    return data_w + data_w / 8 + user_w + 1;
  endfunction

  function automatic int unsigned r_payload_w(int unsigned data_w, int unsigned id_w,
                                              int unsigned user_w);
    return data_w + 2 + 1 + id_w + user_w;
  endfunction

  function automatic int unsigned b_payload_w(int unsigned id_w, int unsigned user_w);
    return 2 + id_w + user_w;
  endfunction

endpackage

// File: rtl/axi_slice_fifo.sv
// Valid/ready FIFO with modulo-DEPTH pointers; DEPTH=0 degenerates to plain wires.
// Ready depends only on the registered count, so no combinational path crosses the slice.
module axi_slice_fifo
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [LEVEL_W-1:0] count
);

  if (DEPTH > 255) begin : g_depth_check
    $error("axi_slice_fifo: DEPTH %0d does not fit the 8-bit level field", DEPTH);
  end

  if (DEPTH == 0) begin : g_bypass
    logic bypass_unused;
    assign bypass_unused = clk ^ rst_n;
    assign out_valid     = in_valid;
    assign in_ready      = out_ready;
    assign out_data      = in_data;
    assign count         = '0;
  end else begin : g_fifo
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop;

    // in_ready is held low during reset so no beat is accepted and then lost
    assign in_ready  = rst_n && (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = LEVEL_W'(cnt_q);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/axi_slice_param.sv
// AXI4 register/buffer slice: five independently sized channel FIFOs between slv and mst.
// Top level only packs/unpacks channel payloads and reports occupancy.
module axi_slice_param
  import axi_slice_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 2,
  parameter int unsigned R_DEPTH        = 2,
  parameter int unsigned B_DEPTH        = 2
) (
  input  logic clk,
  input  logic rst_n,
  // upstream AW/AR/W (master drives these)
  input  logic [AXI_ADDR_WIDTH-1:0] slv_aw_addr,   input  logic [2:0] slv_aw_prot,
  input  logic [3:0] slv_aw_region, input  logic [7:0] slv_aw_len,  input  logic [2:0] slv_aw_size,
  input  logic [1:0] slv_aw_burst,  input  logic slv_aw_lock,       input  logic [3:0] slv_aw_cache,
  input  logic [3:0] slv_aw_qos,    input  logic [AXI_ID_WIDTH-1:0] slv_aw_id,
  input  logic [AXI_USER_WIDTH-1:0] slv_aw_user,   input  logic slv_aw_valid, output logic slv_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] slv_ar_addr,   input  logic [2:0] slv_ar_prot,
  input  logic [3:0] slv_ar_region, input  logic [7:0] slv_ar_len,  input  logic [2:0] slv_ar_size,
  input  logic [1:0] slv_ar_burst,  input  logic slv_ar_lock,       input  logic [3:0] slv_ar_cache,
  input  logic [3:0] slv_ar_qos,    input  logic [AXI_ID_WIDTH-1:0] slv_ar_id,
  input  logic [AXI_USER_WIDTH-1:0] slv_ar_user,   input  logic slv_ar_valid, output logic slv_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0] slv_w_data,    input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb,
  input  logic [AXI_USER_WIDTH-1:0] slv_w_user,    input  logic slv_w_last,
  input  logic slv_w_valid,         output logic slv_w_ready,
  // upstream R/B
  output logic [AXI_DATA_WIDTH-1:0] slv_r_data,    output logic [1:0] slv_r_resp, output logic slv_r_last,
  output logic [AXI_ID_WIDTH-1:0] slv_r_id,        output logic [AXI_USER_WIDTH-1:0] slv_r_user,
  output logic slv_r_valid,         input  logic slv_r_ready,
  output logic [1:0] slv_b_resp,    output logic [AXI_ID_WIDTH-1:0] slv_b_id,
  output logic [AXI_USER_WIDTH-1:0] slv_b_user,    output logic slv_b_valid, input logic slv_b_ready,
  // downstream AW/AR/W
  output logic [AXI_ADDR_WIDTH-1:0] mst_aw_addr,   output logic [2:0] mst_aw_prot,
  output logic [3:0] mst_aw_region, output logic [7:0] mst_aw_len,  output logic [2:0] mst_aw_size,
  output logic [1:0] mst_aw_burst,  output logic mst_aw_lock,       output logic [3:0] mst_aw_cache,
  output logic [3:0] mst_aw_qos,    output logic [AXI_ID_WIDTH-1:0] mst_aw_id,
  output logic [AXI_USER_WIDTH-1:0] mst_aw_user,   output logic mst_aw_valid, input logic mst_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] mst_ar_addr,   output logic [2:0] mst_ar_prot,
  output logic [3:0] mst_ar_region, output logic [7:0] mst_ar_len,  output logic [2:0] mst_ar_size,
  output logic [1:0] mst_ar_burst,  output logic mst_ar_lock,       output logic [3:0] mst_ar_cache,
  output logic [3:0] mst_ar_qos,    output logic [AXI_ID_WIDTH-1:0] mst_ar_id,
  output logic [AXI_USER_WIDTH-1:0] mst_ar_user,   output logic mst_ar_valid, input logic mst_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0] mst_w_data,    output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb,
  output logic [AXI_USER_WIDTH-1:0] mst_w_user,    output logic mst_w_last,
  output logic mst_w_valid,         input  logic mst_w_ready,
  // downstream R/B
  input  logic [AXI_DATA_WIDTH-1:0] mst_r_data,    input  logic [1:0] mst_r_resp, input logic mst_r_last,
  input  logic [AXI_ID_WIDTH-1:0] mst_r_id,        input  logic [AXI_USER_WIDTH-1:0] mst_r_user,
  input  logic mst_r_valid,         output logic mst_r_ready,
  input  logic [1:0] mst_b_resp,    input  logic [AXI_ID_WIDTH-1:0] mst_b_id,
  input  logic [AXI_USER_WIDTH-1:0] mst_b_user,    input  logic mst_b_valid, output logic mst_b_ready,
  output logic busy_o,
  output logic [5*LEVEL_W-1:0] level_o
);

  localparam int unsigned AX_W = ax_payload_w(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned W_W  = w_payload_w(AXI_DATA_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned R_W  = r_payload_w(AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned B_W  = b_payload_w(AXI_ID_WIDTH, AXI_USER_WIDTH);

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [R_W-1:0]  r_in, r_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [LEVEL_W-1:0] aw_cnt, ar_cnt, w_cnt, r_cnt, b_cnt;

  assign aw_in = {slv_aw_addr, slv_aw_prot, slv_aw_region, slv_aw_len, slv_aw_size, slv_aw_burst,
                  slv_aw_lock, slv_aw_cache, slv_aw_qos, slv_aw_id, slv_aw_user};
  assign {mst_aw_addr, mst_aw_prot, mst_aw_region, mst_aw_len, mst_aw_size, mst_aw_burst,
          mst_aw_lock, mst_aw_cache, mst_aw_qos, mst_aw_id, mst_aw_user} = aw_out;
  assign ar_in = {slv_ar_addr, slv_ar_prot, slv_ar_region, slv_ar_len, slv_ar_size, slv_ar_burst,
                  slv_ar_lock, slv_ar_cache, slv_ar_qos, slv_ar_id, slv_ar_user};
  assign {mst_ar_addr, mst_ar_prot, mst_ar_region, mst_ar_len, mst_ar_size, mst_ar_burst,
          mst_ar_lock, mst_ar_cache, mst_ar_qos, mst_ar_id, mst_ar_user} = ar_out;
  assign w_in = {slv_w_data, slv_w_strb, slv_w_user, slv_w_last};
  assign {mst_w_data, mst_w_strb, mst_w_user, mst_w_last} = w_out;
  assign r_in = {mst_r_data, mst_r_resp, mst_r_last, mst_r_id, mst_r_user};
  assign {slv_r_data, slv_r_resp, slv_r_last, slv_r_id, slv_r_user} = r_out;
  assign b_in = {mst_b_resp, mst_b_id, mst_b_user};
  assign {slv_b_resp, slv_b_id, slv_b_user} = b_out;

  axi_slice_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n), .in_valid(slv_aw_valid), .in_ready(slv_aw_ready), .in_data(aw_in),
    .out_valid(mst_aw_valid), .out_ready(mst_aw_ready), .out_data(aw_out), .count(aw_cnt));

  axi_slice_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk), .rst_n(rst_n), .in_valid(slv_ar_valid), .in_ready(slv_ar_ready), .in_data(ar_in),
    .out_valid(mst_ar_valid), .out_ready(mst_ar_ready), .out_data(ar_out), .count(ar_cnt));

  axi_slice_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rst_n(rst_n), .in_valid(slv_w_valid), .in_ready(slv_w_ready), .in_data(w_in),
    .out_valid(mst_w_valid), .out_ready(mst_w_ready), .out_data(w_out), .count(w_cnt));

  axi_slice_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_fifo (
    .clk(clk), .rst_n(rst_n), .in_valid(mst_r_valid), .in_ready(mst_r_ready), .in_data(r_in),
    .out_valid(slv_r_valid), .out_ready(slv_r_ready), .out_data(r_out), .count(r_cnt));

  axi_slice_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rst_n(rst_n), .in_valid(mst_b_valid), .in_ready(mst_b_ready), .in_data(b_in),
    .out_valid(slv_b_valid), .out_ready(slv_b_ready), .out_data(b_out), .count(b_cnt));

  assign level_o = {b_cnt, r_cnt, w_cnt, ar_cnt, aw_cnt};
  assign busy_o  = |level_o;

endmodule

// File: tb/tb_axi_slice_param.sv
// Directed bench for axi_slice_param with AW=2, AR=0 (bypass), W=4, R=2, B=3 entries.
module tb_axi_slice_param;
  import axi_slice_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] slv_aw_addr, slv_ar_addr, mst_aw_addr, mst_ar_addr;
  logic [2:0]  slv_aw_prot, slv_ar_prot, mst_aw_prot, mst_ar_prot;
  logic [3:0]  slv_aw_region, slv_ar_region, mst_aw_region, mst_ar_region;
  logic [7:0]  slv_aw_len, slv_ar_len, mst_aw_len, mst_ar_len;
  logic [2:0]  slv_aw_size, slv_ar_size, mst_aw_size, mst_ar_size;
  logic [1:0]  slv_aw_burst, slv_ar_burst, mst_aw_burst, mst_ar_burst;
  logic        slv_aw_lock, slv_ar_lock, mst_aw_lock, mst_ar_lock;
  logic [3:0]  slv_aw_cache, slv_ar_cache, mst_aw_cache, mst_ar_cache;
  logic [3:0]  slv_aw_qos, slv_ar_qos, mst_aw_qos, mst_ar_qos;
  logic [9:0]  slv_aw_id, slv_ar_id, mst_aw_id, mst_ar_id;
  logic [5:0]  slv_aw_user, slv_ar_user, mst_aw_user, mst_ar_user;
  logic        slv_aw_valid, slv_aw_ready, slv_ar_valid, slv_ar_ready;
  logic        mst_aw_valid, mst_aw_ready, mst_ar_valid, mst_ar_ready;
  logic [63:0] slv_w_data, mst_w_data, slv_r_data, mst_r_data;
  logic [7:0]  slv_w_strb, mst_w_strb;
  logic [5:0]  slv_w_user, mst_w_user, slv_r_user, mst_r_user, slv_b_user, mst_b_user;
  logic        slv_w_last, mst_w_last, slv_r_last, mst_r_last;
  logic        slv_w_valid, slv_w_ready, mst_w_valid, mst_w_ready;
  logic [1:0]  slv_r_resp, mst_r_resp, slv_b_resp, mst_b_resp;
  logic [9:0]  slv_r_id, mst_r_id, slv_b_id, mst_b_id;
  logic        slv_r_valid, slv_r_ready, mst_r_valid, mst_r_ready;
  logic        slv_b_valid, slv_b_ready, mst_b_valid, mst_b_ready;
  logic        busy_o;
  logic [39:0] level_o;

  axi_slice_param #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6),
    .AW_DEPTH(2), .AR_DEPTH(0), .W_DEPTH(4), .R_DEPTH(2), .B_DEPTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slv_aw_addr(slv_aw_addr), .slv_aw_prot(slv_aw_prot), .slv_aw_region(slv_aw_region),
    .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size), .slv_aw_burst(slv_aw_burst),
    .slv_aw_lock(slv_aw_lock), .slv_aw_cache(slv_aw_cache), .slv_aw_qos(slv_aw_qos),
    .slv_aw_id(slv_aw_id), .slv_aw_user(slv_aw_user), .slv_aw_valid(slv_aw_valid),
    .slv_aw_ready(slv_aw_ready),
    .slv_ar_addr(slv_ar_addr), .slv_ar_prot(slv_ar_prot), .slv_ar_region(slv_ar_region),
    .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size), .slv_ar_burst(slv_ar_burst),
    .slv_ar_lock(slv_ar_lock), .slv_ar_cache(slv_ar_cache), .slv_ar_qos(slv_ar_qos),
    .slv_ar_id(slv_ar_id), .slv_ar_user(slv_ar_user), .slv_ar_valid(slv_ar_valid),
    .slv_ar_ready(slv_ar_ready),
    .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_user(slv_w_user),
    .slv_w_last(slv_w_last), .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
    .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
    .slv_r_id(slv_r_id), .slv_r_user(slv_r_user), .slv_r_valid(slv_r_valid),
    .slv_r_ready(slv_r_ready),
    .slv_b_resp(slv_b_resp), .slv_b_id(slv_b_id), .slv_b_user(slv_b_user),
    .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
    .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot), .mst_aw_region(mst_aw_region),
    .mst_aw_len(mst_aw_len), .mst_aw_size(mst_aw_size), .mst_aw_burst(mst_aw_burst),
    .mst_aw_lock(mst_aw_lock), .mst_aw_cache(mst_aw_cache), .mst_aw_qos(mst_aw_qos),
    .mst_aw_id(mst_aw_id), .mst_aw_user(mst_aw_user), .mst_aw_valid(mst_aw_valid),
    .mst_aw_ready(mst_aw_ready),
    .mst_ar_addr(mst_ar_addr), .mst_ar_prot(mst_ar_prot), .mst_ar_region(mst_ar_region),
    .mst_ar_len(mst_ar_len), .mst_ar_size(mst_ar_size), .mst_ar_burst(mst_ar_burst),
    .mst_ar_lock(mst_ar_lock), .mst_ar_cache(mst_ar_cache), .mst_ar_qos(mst_ar_qos),
    .mst_ar_id(mst_ar_id), .mst_ar_user(mst_ar_user), .mst_ar_valid(mst_ar_valid),
    .mst_ar_ready(mst_ar_ready),
    .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_user(mst_w_user),
    .mst_w_last(mst_w_last), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
    .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last),
    .mst_r_id(mst_r_id), .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid),
    .mst_r_ready(mst_r_ready),
    .mst_b_resp(mst_b_resp), .mst_b_id(mst_b_id), .mst_b_user(mst_b_user),
    .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
    .busy_o(busy_o), .level_o(level_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lvl(input int ch);
    return level_o[ch*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam int AW = 0, AR = 1, W = 2, R = 3, B = 4;
  localparam logic [63:0] W_BASE = 64'h1111_0000_0000_0000;
  localparam logic [63:0] R_BASE = 64'h2222_0000_0000_0000;

  int sent, recv, mcnt, cyc;
  logic [9:0] bq[$];
  logic push_m, pop_m;

  initial begin
    {slv_aw_addr, slv_aw_prot, slv_aw_region, slv_aw_len, slv_aw_size, slv_aw_burst,
     slv_aw_lock, slv_aw_cache, slv_aw_qos, slv_aw_id, slv_aw_user, slv_aw_valid} = '0;
    {slv_ar_addr, slv_ar_prot, slv_ar_region, slv_ar_len, slv_ar_size, slv_ar_burst,
     slv_ar_lock, slv_ar_cache, slv_ar_qos, slv_ar_id, slv_ar_user, slv_ar_valid} = '0;
    {slv_w_data, slv_w_strb, slv_w_user, slv_w_last, slv_w_valid} = '0;
    {mst_r_data, mst_r_resp, mst_r_last, mst_r_id, mst_r_user, mst_r_valid} = '0;
    {mst_b_resp, mst_b_id, mst_b_user, mst_b_valid} = '0;
    mst_aw_ready = 1'b1; mst_ar_ready = 1'b1; mst_w_ready = 1'b1;
    slv_r_ready = 1'b1; slv_b_ready = 1'b1;

    // reset: readies gated low, then released
    step(); step();
    chk("rst_aw_ready", slv_aw_ready, 0);
    chk("rst_w_ready", slv_w_ready, 0);
    chk("rst_r_ready", mst_r_ready, 0);
    chk("rst_b_ready", mst_b_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_aw_ready", slv_aw_ready, 1);
    chk("post_w_ready", slv_w_ready, 1);
    chk("post_r_ready", mst_r_ready, 1);
    chk("post_b_ready", mst_b_ready, 1);
    chk("post_aw_valid", mst_aw_valid, 0);
    chk("post_w_valid", mst_w_valid, 0);
    chk("post_r_valid", slv_r_valid, 0);
    chk("post_b_valid", slv_b_valid, 0);
    chk("post_busy", busy_o, 0);
    chk("post_level", level_o, 0);

    // single write
    step();
    slv_aw_valid = 1; slv_aw_addr = 32'h1A10_0000; slv_aw_len = 0; slv_aw_id = 10'h005;
    slv_w_valid = 1; slv_w_data = 64'hDEAD_BEEF_00C0_FFEE; slv_w_strb = 8'hFF; slv_w_last = 1;
    #1;
    chk("wr_aw_ready", slv_aw_ready, 1);
    chk("wr_aw_no_comb", mst_aw_valid, 0);
    chk("wr_w_no_comb", mst_w_valid, 0);
    step();
    slv_aw_valid = 0; slv_w_valid = 0;
    #1;
    chk("wr_mst_aw_valid", mst_aw_valid, 1);
    chk("wr_mst_aw_addr", mst_aw_addr, 32'h1A10_0000);
    chk("wr_mst_aw_id", mst_aw_id, 10'h005);
    chk("wr_mst_w_valid", mst_w_valid, 1);
    chk("wr_mst_w_data", mst_w_data, 64'hDEAD_BEEF_00C0_FFEE);
    chk("wr_mst_w_strb", mst_w_strb, 8'hFF);
    chk("wr_mst_w_last", mst_w_last, 1);
    chk("wr_level_aw", lvl(AW), 1);
    chk("wr_level_w", lvl(W), 1);
    chk("wr_busy", busy_o, 1);
    step();
    #1;
    chk("wr_aw_drained", mst_aw_valid, 0);
    chk("wr_w_drained", mst_w_valid, 0);
    mst_b_valid = 1; mst_b_id = 10'h005; mst_b_resp = AXI_RESP_OKAY;
    #1;
    chk("wr_b_latency", slv_b_valid, 0);
    step();
    mst_b_valid = 0;
    #1;
    chk("wr_slv_b_valid", slv_b_valid, 1);
    chk("wr_slv_b_id", slv_b_id, 10'h005);
    chk("wr_slv_b_resp", slv_b_resp, AXI_RESP_OKAY);
    chk("wr_level_b", lvl(B), 1);
    step();
    #1;
    chk("wr_b_done", slv_b_valid, 0);
    chk("wr_busy_idle", busy_o, 0);

    // back-pressure on W (4 entries): beats 0..3 fill, beat 4 stalls
    mst_w_ready = 0; slv_w_last = 0;
    for (int i = 0; i < 4; i++) begin
      slv_w_valid = 1; slv_w_data = W_BASE + 64'(i);
      #1;
      chk("bp_fill_ready", slv_w_ready, 1);
      step();
    end
    slv_w_data = W_BASE + 64'd4;
    #1;
    chk("bp_full_ready", slv_w_ready, 0);
    chk("bp_level_w", lvl(W), 4);
    chk("bp_head", mst_w_data, W_BASE);
    step();
    chk("bp_head_stable", mst_w_data, W_BASE);
    chk("bp_still_full", slv_w_ready, 0);
    mst_w_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin slv_w_data = W_BASE + 64'd5; slv_w_last = 1; end
      if (k == 3) slv_w_valid = 0;
      #1;
      if (k < 3) chk("bp_drain_ready", slv_w_ready, (k != 0) ? 64'd1 : 64'd0);
      chk("bp_out_valid", mst_w_valid, 1);
      chk("bp_out_data", mst_w_data, W_BASE + 64'(k));
      chk("bp_out_last", mst_w_last, (k == 5) ? 64'd1 : 64'd0);
      step();
    end
    slv_w_last = 0;
    chk("bp_empty", mst_w_valid, 0);
    chk("bp_level_w0", lvl(W), 0);

    // full-rate R streaming, 16 beats
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        mst_r_valid = 1; mst_r_data = R_BASE + 64'(c); mst_r_id = 10'h003;
        mst_r_last = (c == 15);
      end else begin
        mst_r_valid = 0; mst_r_last = 0;
      end
      #1;
      if (c < 16) chk("rs_in_ready", mst_r_ready, 1);
      if (c == 0) chk("rs_latency", slv_r_valid, 0);
      else begin
        chk("rs_valid", slv_r_valid, 1);
        chk("rs_data", slv_r_data, R_BASE + 64'(c - 1));
        chk("rs_last", slv_r_last, (c == 16) ? 64'd1 : 64'd0);
        chk("rs_id", slv_r_id, 10'h003);
      end
      step();
    end
    chk("rs_done", slv_r_valid, 0);

    // AR bypass: same-cycle valid/addr, ready passed straight back
    slv_ar_valid = 1; slv_ar_addr = 32'h0010_0004; slv_ar_id = 10'h007; mst_ar_ready = 0;
    #1;
    chk("byp_valid", mst_ar_valid, 1);
    chk("byp_addr", mst_ar_addr, 32'h0010_0004);
    chk("byp_id", mst_ar_id, 10'h007);
    chk("byp_ready0", slv_ar_ready, 0);
    chk("byp_level", lvl(AR), 0);
    mst_ar_ready = 1;
    #1;
    chk("byp_ready1", slv_ar_ready, 1);
    step();
    slv_ar_valid = 0;
    #1;
    chk("byp_valid_off", mst_ar_valid, 0);

    // reset mid-operation with two AW entries buffered
    mst_aw_ready = 0;
    slv_aw_valid = 1; slv_aw_addr = 32'hAAAA_0001; slv_aw_id = 10'h011;
    step();
    slv_aw_addr = 32'hAAAA_0002; slv_aw_id = 10'h012;
    step();
    slv_aw_valid = 0;
    #1;
    chk("mr_level_aw", lvl(AW), 2);
    chk("mr_full", slv_aw_ready, 0);
    rst_n = 0;
    #1;
    chk("mr_aw_ready_gate", slv_aw_ready, 0);
    chk("mr_w_ready_gate", slv_w_ready, 0);
    chk("mr_r_ready_gate", mst_r_ready, 0);
    chk("mr_b_ready_gate", mst_b_ready, 0);
    step();
    chk("mr_level", level_o, 0);
    chk("mr_aw_valid", mst_aw_valid, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_aw_ready_rst", slv_aw_ready, 0);
    rst_n = 1;
    mst_aw_ready = 1;
    #1;
    chk("mr_aw_ready_after", slv_aw_ready, 1);
    chk("mr_b_ready_after", mst_b_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_old_aw", mst_aw_valid, 0);
    end

    // B (3 entries): random slv ready, in-order IDs through pointer wrap
    sent = 0; recv = 0; mcnt = 0; cyc = 0;
    while (recv < 10 && cyc < 200) begin
      mst_b_valid = (sent < 10);
      mst_b_id = 10'(10'h010 + sent);
      mst_b_resp = AXI_RESP_OKAY;
      slv_b_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bw_level", lvl(B), 8'(mcnt));
      chk("bw_in_ready", mst_b_ready, (mcnt < 3) ? 64'd1 : 64'd0);
      chk("bw_out_valid", slv_b_valid, (mcnt > 0) ? 64'd1 : 64'd0);
      push_m = mst_b_valid && (mcnt < 3);
      pop_m = (mcnt > 0) && slv_b_ready;
      if (pop_m) begin
        chk("bw_id_order", slv_b_id, bq[0]);
        void'(bq.pop_front());
        recv++;
      end
      if (push_m) begin
        bq.push_back(mst_b_id);
        sent++;
      end
      mcnt = mcnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      cyc++;
      step();
    end
    mst_b_valid = 0;
    chk("bw_all_received", recv, 10);
    #1;
    chk("bw_end_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
